nibble_display_driver: RTL
==========================

# nibble_display_driver

Drives one active-low Go Board seven-segment digit from the 4-bit nibble produced by the switch-toggle counter. The block registers the nibble, decodes it to hexadecimal glyphs (0-9, A, b, C, d, E, F), and flashes the digit on every value change so the user sees each press acknowledged. It sits between the nibble source and the top-level segment pins, in the same clock domain as the source.

## Interface
- FLASH_HALF_PERIOD, 2_500_000: cycles per blank phase and per lit phase of a flash (100 ms at 25 MHz); must be ≥ 2.
- FLASH_COUNT, 3: number of blank phases per change notification; must be ≥ 1.
- i_Clk  input  1  system clock, all logic on posedge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Nibble  input  4  value to display; synchronous to i_Clk.
- o_Segments  output  7  active-low segments, bit 0 = A … bit 6 = G; registered.
- o_Busy  output  1  high while a flash sequence is in progress; registered.

## Operation
- Held value r_Nibble is updated only when i_Nibble != r_Nibble. The update is a change event.
- Active-high glyph codes, with bit 6 = G: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. o_Segments is the bitwise inverse of the code. Blank is 7'h7F.
- FSM states:
  - IDLE: shows the glyph of r_Nibble. o_Busy=0.
  - BLANK: o_Segments=7'h7F. o_Busy=1.
  - LIT: shows the glyph. o_Busy=1.
- Transitions:
  - IDLE + change event → BLANK. Phase timer cleared, flash counter cleared.
  - BLANK, timer reaches FLASH_HALF_PERIOD-1 → LIT. Timer cleared, flash counter increments.
  - LIT, timer reaches FLASH_HALF_PERIOD-1 → IDLE if flash counter == FLASH_COUNT, else → BLANK. Timer cleared.
  - Change event in BLANK or LIT → restart at BLANK. Timer and flash counter are cleared and the new value is latched. The flash restarts; sequences are never queued.
- Timer width: $clog2(FLASH_HALF_PERIOD). Flash counter width: $clog2(FLASH_COUNT+1). Neither counter wraps, because both are cleared at each terminal condition.
- Reset: r_Nibble=0, state IDLE, timer=0, counter=0, o_Segments=7'h40 (glyph '0'), o_Busy=0.

## Timing
- Change event latency: if i_Nibble differs at the edge ending cycle N, then from cycle N+1 o_Segments=7'h7F, o_Busy=1, and r_Nibble holds the new value.
- Each BLANK phase and each LIT phase lasts exactly FLASH_HALF_PERIOD cycles.
- A full sequence lasts 2·FLASH_COUNT·FLASH_HALF_PERIOD cycles from the first blank cycle. At the end, o_Busy falls on the same edge that enters IDLE, and the glyph stays lit continuously.
- A change on the same edge as a phase expiry takes priority: the next state is BLANK with counters cleared.
- Asserting reset at any point forces reset values immediately, independent of the clock. After release, the first change event is evaluated against r_Nibble=0.
- No input synchronizer inside the block; i_Nibble is already registered in i_Clk.

## Structure
- Shared package/include holds:
  - the 16 glyph constants,
  - SEG_BLANK = 7'h7F,
  - the FSM state encoding (IDLE, BLANK, LIT).
- Sub-module hex_to_7seg: purely combinational, 4-bit value in, active-low 7-bit segments out.
- The top block owns the FSM, the phase timer, the flash counter, and the output registers.

## Test plan
All scenarios use FLASH_HALF_PERIOD=4 and FLASH_COUNT=2.
- Reset with i_Nibble=0 held → o_Segments=7'h40 and o_Busy=0 indefinitely, with no flash.
- i_Nibble 0→5 → next cycle o_Segments=7'h7F for 4 cycles, then 7'h12 for 4, 7'h7F for 4, 7'h12 for 4. o_Busy is high for exactly 16 cycles, then o_Segments holds 7'h12.
- i_Nibble steps through 0..F, each value held 20 cycles → settled o_Segments equals the inverse of each listed glyph code.
- i_Nibble 5→A in the 3rd LIT cycle → BLANK on the next cycle, then a full 16-cycle sequence settling on 7'h08.
- i_Nibble change coincident with the final LIT cycle → no IDLE cycle; BLANK follows directly and o_Busy stays high.
- Reset asserted mid-BLANK, asynchronously between edges → o_Segments=7'h40 and o_Busy=0 without waiting for a clock edge. With i_Nibble still 5 after release → a new flash sequence starts.

Source files
------------

// File: rtl/nibble_display_driver_pkg.sv
// Shared constants for the nibble display driver: hex glyph codes (active-high,
// bit 6 = G), blank pattern and FSM state encoding.
package nibble_display_driver_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // Active-low pattern with every segment off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        LIT   = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_display_driver_hex_to_7seg.sv
// Combinational hex digit decoder producing active-low seven-segment drive.
module hex_to_7seg
    import nibble_display_driver_pkg::*;
(
    input  logic [3:0] i_Value,
    output logic [6:0] o_Segments_c
);

    logic [6:0] glyph_c;

    always_comb begin
        glyph_c = GLYPH_0;
        case (i_Value)
            4'h0: glyph_c = GLYPH_0;
            4'h1: glyph_c = GLYPH_1;
            4'h2: glyph_c = GLYPH_2;
            4'h3: glyph_c = GLYPH_3;
            4'h4: glyph_c = GLYPH_4;
            4'h5: glyph_c = GLYPH_5;
            4'h6: glyph_c = GLYPH_6;
            4'h7: glyph_c = GLYPH_7;
            4'h8: glyph_c = GLYPH_8;
            4'h9: glyph_c = GLYPH_9;
            4'hA: glyph_c = GLYPH_A;
            4'hB: glyph_c = GLYPH_B;
            4'hC: glyph_c = GLYPH_C;
            4'hD: glyph_c = GLYPH_D;
            4'hE: glyph_c = GLYPH_E;
            4'hF: glyph_c = GLYPH_F;
            default: glyph_c = GLYPH_0;
        endcase
    end

    assign o_Segments_c = ~glyph_c;

endmodule

// File: rtl/nibble_display_driver.sv
// Holds the last nibble, shows it as a hex glyph and blinks the digit
// FLASH_COUNT times whenever the value changes.
module nibble_display_driver
    import nibble_display_driver_pkg::*;
#(
    parameter int unsigned FLASH_HALF_PERIOD = 2_500_000,
    parameter int unsigned FLASH_COUNT       = 3
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Segments,
    output logic       o_Busy
);

    localparam int unsigned TIMER_W = $clog2(FLASH_HALF_PERIOD);
    localparam int unsigned COUNT_W = $clog2(FLASH_COUNT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FLASH_HALF_PERIOD - 1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(FLASH_COUNT);

    state_t             r_State;
    logic [3:0]         r_Nibble;
    logic [TIMER_W-1:0] r_Timer;
    logic [COUNT_W-1:0] r_Count;
    logic [6:0]         glyph_c;
    logic               change_c;
    logic               phase_done_c;

    hex_to_7seg u_hex_to_7seg (
        .i_Value      (r_Nibble),
        .o_Segments_c (glyph_c)
    );

    assign change_c     = (i_Nibble != r_Nibble);
    assign phase_done_c = (r_Timer == TIMER_LAST);

    // A change always wins over phase expiry and restarts the flash from scratch
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State    <= IDLE;
            r_Nibble   <= 4'h0;
            r_Timer    <= '0;
            r_Count    <= '0;
            o_Segments <= ~GLYPH_0;
            o_Busy     <= 1'b0;
        end else if (change_c) begin
            r_State    <= BLANK;
            r_Nibble   <= i_Nibble;
            r_Timer    <= '0;
            r_Count    <= '0;
            o_Segments <= SEG_BLANK;
            o_Busy     <= 1'b1;
        end else begin
            case (r_State)
                IDLE: begin
                    o_Segments <= glyph_c;
                    o_Busy     <= 1'b0;
                end
                BLANK: begin
                    if (phase_done_c) begin
                        r_State    <= LIT;
                        r_Timer    <= '0;
                        r_Count    <= r_Count + COUNT_W'(1);
                        o_Segments <= glyph_c;
                    end else begin
                        r_Timer <= r_Timer + TIMER_W'(1);
                    end
                end
                LIT: begin
                    if (phase_done_c) begin
                        r_Timer <= '0;
                        if (r_Count == COUNT_LAST) begin
                            r_State    <= IDLE;
                            o_Segments <= glyph_c;
                            o_Busy     <= 1'b0;
                        end else begin
                            r_State    <= BLANK;
                            o_Segments <= SEG_BLANK;
                        end
                    end else begin
                        r_Timer <= r_Timer + TIMER_W'(1);
                    end
                end
                default: begin
                    r_State    <= IDLE;
                    o_Segments <= glyph_c;
                    o_Busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
